// File: rtl/sqrt_stage2_if.sv
// Handshake and result bundle between the stage-1 feed, sqrt_stage2 and the next pipeline stage.
interface sqrt_stage2_if #(
  parameter int ROOT_WIDTH = 8
);
  logic                      en_pipe_i;
  logic                      valid_i;
  logic [2*ROOT_WIDTH-1:0]   input_i;
  logic                      ready_o;
  logic                      valid_o;
  logic                      ready_i;
  logic [ROOT_WIDTH-1:0]     root_o;
  logic [2*ROOT_WIDTH:0]     square_o;
  logic [ROOT_WIDTH:0]       rem_o;

  modport slave (
    input  en_pipe_i, valid_i, input_i, ready_i,
    output ready_o, valid_o, root_o, square_o, rem_o
  );

  modport master (
    output en_pipe_i, valid_i, input_i, ready_i,
    input  ready_o, valid_o, root_o, square_o, rem_o
  );
endinterface

// File: rtl/sqrt_stage2.sv
// Pipelined square-root stage 2: restoring trial-square floor sqrt, one root bit per enabled cycle,
// with a valid/ready result port and a global pipe enable that freezes all state.
module sqrt_stage2 #(
  parameter int ROOT_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  sqrt_stage2_if.slave bus
);
  localparam int RW = 2 * ROOT_WIDTH;
  localparam int SW = 2 * ROOT_WIDTH + 1;
  localparam int MW = ROOT_WIDTH + 1;
  localparam int KW = (ROOT_WIDTH > 1) ? $clog2(ROOT_WIDTH) : 1;
  localparam logic [KW-1:0]         K_MAX    = KW'(ROOT_WIDTH - 1);
  localparam logic [KW-1:0]         K_ONE    = KW'(1);
  localparam logic [SW-1:0]         SQ_ONE   = SW'(1);
  localparam logic [ROOT_WIDTH-1:0] ROOT_ONE = ROOT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [KW-1:0]         r_k;
  logic [RW-1:0]         r_rad;
  logic [ROOT_WIDTH-1:0] r_root;
  logic [SW-1:0]         r_sq;
  logic [ROOT_WIDTH-1:0] r_root_o;
  logic [SW-1:0]         r_square_o;
  logic [MW-1:0]         r_rem_o;

  logic                  w_ready;
  logic                  w_valid;
  logic                  w_accept;
  logic                  w_deliver;
  logic                  w_k_last;
  logic                  w_fit;
  logic [SW-1:0]         w_trial;
  logic [SW-1:0]         w_sq_new;
  logic [ROOT_WIDTH-1:0] w_root_new;
  logic [MW-1:0]         w_rem;

  assign w_accept  = bus.valid_i & w_ready;
  assign w_deliver = w_valid & bus.ready_i;
  assign w_k_last  = (r_k == {KW{1'b0}});

  // (sq + 2^k * root * 2 + 2^2k) == (root + 2^k)^2 given root has no bits below k yet
  assign w_trial    = r_sq
                    + ({{(SW-ROOT_WIDTH){1'b0}}, r_root} << ({1'b0, r_k} + {{KW{1'b0}}, 1'b1}))
                    + (SQ_ONE << {r_k, 1'b0});
  assign w_fit      = (w_trial <= {1'b0, r_rad});
  assign w_sq_new   = w_fit ? w_trial : r_sq;
  assign w_root_new = w_fit ? (r_root | (ROOT_ONE << r_k)) : r_root;
  // Remainder is at most 2*root, so the low MW bits of the difference are exact
  assign w_rem      = r_rad[MW-1:0] - w_sq_new[MW-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = CALC;
        else          w_next_state = IDLE;
      end
      CALC: begin
        if (bus.en_pipe_i && w_k_last) w_next_state = DONE;
        else                           w_next_state = CALC;
      end
      DONE: begin
        if (w_deliver) w_next_state = IDLE;
        else           w_next_state = DONE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake outputs, gated by the pipe enable
  always_comb begin
    w_ready = 1'b0;
    w_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = bus.en_pipe_i;
        w_valid = 1'b0;
      end
      CALC: begin
        w_ready = 1'b0;
        w_valid = 1'b0;
      end
      DONE: begin
        w_ready = 1'b0;
        w_valid = bus.en_pipe_i;
      end
      default: begin
        w_ready = 1'b0;
        w_valid = 1'b0;
      end
    endcase
  end

  // Datapath and result registers; results load only on the last resolving edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k        <= K_MAX;
      r_rad      <= {RW{1'b0}};
      r_root     <= {ROOT_WIDTH{1'b0}};
      r_sq       <= {SW{1'b0}};
      r_root_o   <= {ROOT_WIDTH{1'b0}};
      r_square_o <= {SW{1'b0}};
      r_rem_o    <= {MW{1'b0}};
    end else if (bus.en_pipe_i) begin
      if (w_accept) begin
        r_rad  <= bus.input_i;
        r_root <= {ROOT_WIDTH{1'b0}};
        r_sq   <= {SW{1'b0}};
        r_k    <= K_MAX;
      end else if (r_state == CALC) begin
        r_root <= w_root_new;
        r_sq   <= w_sq_new;
        if (w_k_last) begin
          r_k        <= K_MAX;
          r_root_o   <= w_root_new;
          r_square_o <= w_sq_new;
          r_rem_o    <= w_rem;
        end else begin
          r_k <= r_k - K_ONE;
        end
      end
    end
  end

  assign bus.ready_o  = w_ready;
  assign bus.valid_o  = w_valid;
  assign bus.root_o   = r_root_o;
  assign bus.square_o = r_square_o;
  assign bus.rem_o    = r_rem_o;
endmodule

// File: tb/tb_sqrt_stage2.sv
// Bench for sqrt_stage2: directed corners, stall, backpressure and reset, then random traffic
// scored against a floor-sqrt model with a per-cycle handshake timing model.
module tb_sqrt_stage2;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sqrt_stage2_if #(.ROOT_WIDTH(8)) bus ();

  sqrt_stage2 #(.ROOT_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int phase    = 0;
  int cnt      = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int latency  = -1;
  int last_rad = 0;
  int n_in     = 0;
  int n_out    = 0;
  int q[$];

  function automatic int isqrt(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive at the falling edge, check, take the rising edge, advance the model.
  task automatic cycle(input bit en, input bit vin, input logic [15:0] din, input bit rdy);
    int rad;
    int r;
    bus.en_pipe_i = en;
    bus.valid_i   = vin;
    bus.input_i   = din;
    bus.ready_i   = rdy;
    #1;
    check("ready_o", bus.ready_o, (phase == 0 && en) ? 1 : 0);
    check("valid_o", bus.valid_o, (phase == 2 && en) ? 1 : 0);
    if (bus.valid_o && latency < 0) latency = cyc - acc_cyc - 1;
    rad = (phase == 2 && q.size() > 0) ? q[0] : last_rad;
    r   = isqrt(rad);
    check("root_o",   bus.root_o,   r);
    check("square_o", bus.square_o, r * r);
    check("rem_o",    bus.rem_o,    rad - r * r);
    @(posedge clk);
    if (en) begin
      case (phase)
        0: if (vin) begin
          q.push_back(int'(din));
          phase   = 1;
          cnt     = 0;
          acc_cyc = cyc;
          latency = -1;
          n_in++;
        end
        1: begin
          cnt++;
          if (cnt == 8) phase = 2;
        end
        2: if (rdy) begin
          last_rad = q.pop_front();
          n_out++;
          phase = 0;
        end
        default: phase = 0;
      endcase
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_one(input int din, input int stall);
    cycle(1'b1, 1'b1, 16'(din), 1'b1);
    for (int i = 0; i < 40 && phase != 0; i++)
      cycle(!(i >= 2 && i < 2 + stall), 1'b0, 16'd0, 1'b1);
    check("latency", latency, 8 + stall);
  endtask

  initial begin
    int n_start;
    bit en, vin, rdy;
    logic [15:0] d;
    int tmp;

    rst_n         = 1'b0;
    bus.en_pipe_i = 1'b1;
    bus.valid_i   = 1'b0;
    bus.input_i   = 16'd0;
    bus.ready_i   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.valid_o, 0);
    check("rst_ready", bus.ready_o, 1);
    check("rst_root",  bus.root_o, 0);
    check("rst_sq",    bus.square_o, 0);
    check("rst_rem",   bus.rem_o, 0);
    rst_n = 1'b1;
    repeat (2) cycle(1'b1, 1'b0, 16'd0, 1'b1);

    run_one(0, 0);
    run_one(65535, 0);
    run_one(144, 0);
    run_one(143, 0);
    run_one(1, 0);
    run_one(2, 0);
    run_one(20000, 3);

    // Backpressure with a competing radicand held on the input
    cycle(1'b1, 1'b1, 16'd50000, 1'b0);
    for (int i = 0; i < 20 && phase != 2; i++) cycle(1'b1, 1'b0, 16'd0, 1'b0);
    repeat (5) cycle(1'b1, 1'b1, 16'd777, 1'b0);
    cycle(1'b1, 1'b1, 16'd777, 1'b1);
    check("bp_second_pending", n_in - n_out, 0);
    cycle(1'b1, 1'b1, 16'd777, 1'b1);
    for (int i = 0; i < 30 && phase != 0; i++) cycle(1'b1, 1'b0, 16'd0, 1'b1);

    // Asynchronous reset in the middle of a computation
    cycle(1'b1, 1'b1, 16'd1000, 1'b1);
    repeat (3) cycle(1'b1, 1'b0, 16'd0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.valid_o, 0);
    check("mid_rst_ready", bus.ready_o, 1);
    check("mid_rst_root",  bus.root_o, 0);
    check("mid_rst_sq",    bus.square_o, 0);
    check("mid_rst_rem",   bus.rem_o, 0);
    phase    = 0;
    last_rad = 0;
    n_in     = n_in - q.size();
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) cycle(1'b1, 1'b0, 16'd0, 1'b1);

    n_start = n_in;
    for (int t = 0; t < 40000 && (n_in - n_start) < 1000; t++) begin
      en  = ($urandom_range(0, 9) != 0);
      vin = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0: d = 16'd0;
        1: d = 16'hFFFF;
        2: begin
          tmp = $urandom_range(0, 255);
          d   = 16'(tmp * tmp);
        end
        default: d = 16'($urandom);
      endcase
      cycle(en, vin, d, rdy);
    end
    check("rand_accepted", n_in - n_start, 1000);
    for (int i = 0; i < 60 && phase != 0; i++) cycle(1'b1, 1'b0, 16'd0, 1'b1);
    check("no_loss_or_dup", n_out, n_in);
    check("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sqrt_stage2.md
# sqrt_stage2

Second stage of the pipelined square-root datapath. It accepts the 16-bit radicand registered by stage 1 and resolves the 8-bit floor square root one bit per enabled cycle, using a restoring trial-square method. It publishes the root, its square and the remainder to the next stage through a valid/ready handshake. The global pipe enable freezes the block without losing state.

## Interface
Parameters:
- ROOT_WIDTH, default 8: root width. Radicand width is 2*ROOT_WIDTH, square width is 2*ROOT_WIDTH+1, remainder width is ROOT_WIDTH+1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset; one clock, with asynchronous active-low reset.
- en_pipe_i  in  1  global pipe enable; low freezes every register and blocks both handshakes.
- valid_i  in  1  radicand on input_i is valid.
- input_i  in  2*ROOT_WIDTH  radicand from stage 1.
- ready_o  out  1  block can accept a radicand.
- valid_o  out  1  result outputs are valid.
- ready_i  in  1  downstream accepts the result.
- root_o  out  ROOT_WIDTH  floor(sqrt(radicand)).
- square_o  out  2*ROOT_WIDTH+1  root_o squared.
- rem_o  out  ROOT_WIDTH+1  radicand minus square_o.

## Operation
- FSM states:
  - IDLE: waiting for a radicand.
  - CALC: resolving bits, bit index k from ROOT_WIDTH-1 down to 0.
  - DONE: holding the result.
- Handshake outputs:
  - ready_o = (state==IDLE) & en_pipe_i.
  - valid_o = (state==DONE) & en_pipe_i.
- Input accept: occurs at the edge where valid_i & ready_o.
  - Latch input_i into an internal radicand register; input_i may change afterwards.
  - Clear the internal root and square registers.
  - Set k = ROOT_WIDTH-1 and go to CALC.
- Each enabled CALC cycle:
  - trial_sq = sq + (root << (k+1)) + (1 << 2k), computed at 2*ROOT_WIDTH+1 bits with no overflow possible.
  - If trial_sq <= radicand: root[k] = 1 and sq = trial_sq. Otherwise both are unchanged.
  - If k==0, go to DONE. Otherwise decrement k.
- DONE:
  - root_o, square_o and rem_o = radicand - sq are registered and held stable while valid_o & !ready_i.
  - At the edge where valid_o & ready_i, go to IDLE. The result outputs keep their last values.
- en_pipe_i low: state, k, radicand, root and sq hold. ready_o and valid_o are forced low, so no transfer occurs.
- No new radicand is accepted in CALC or DONE. Output handshake and input accept can never coincide.
- Reset (async, any state, including mid-CALC):
  - state=IDLE, k=ROOT_WIDTH-1.
  - radicand, root, sq, root_o, square_o and rem_o all 0.
  - valid_o=0. ready_o follows en_pipe_i.
  - Any in-flight computation is discarded.

## Timing
- Latency, en_pipe_i held high: accept at edge E0, CALC edges E1..E8, state DONE after E8, valid_o high in the cycle following E8. That is 8 cycles from accept to valid, for ROOT_WIDTH=8.
- Each low en_pipe_i cycle during CALC or DONE adds exactly one cycle of delay.
- Minimum initiation interval is 10 cycles: accept, 8 CALC cycles, 1 DONE cycle with ready_i=1. ready_o is high again in the cycle after the output handshake.
- The result registers update at the E8 edge (the last CALC edge) only. They are stable for the whole DONE period.
- No combinational path from input_i to any output. ready_o and valid_o depend combinationally only on state and en_pipe_i.

## Test plan
- Reset then idle, en_pipe_i=1:
  - Expect valid_o=0, ready_o=1, root_o=0, square_o=0, rem_o=0.
  - Assert rst_n low mid-CALC: same values immediately, and no valid_o follows.
- Corner values:
  - input 0 -> root 0, square 0, rem 0.
  - input 65535 -> root 255, square 65025, rem 510.
  - Both with valid_o exactly 8 cycles after accept.
- Exact and non-exact squares:
  - 144 -> 12/144/0.
  - 143 -> 11/121/22.
  - 1 -> 1/1/0.
  - 2 -> 1/1/1.
- Stall: pulse en_pipe_i low for 3 cycles during CALC -> valid_o appears 11 cycles after accept with the same result. valid_o and ready_o stay low while en_pipe_i is low.
- Backpressure: ready_i low for 5 cycles in DONE.
  - Outputs stay stable and ready_o stays 0.
  - Releasing ready_i returns the block to IDLE, and ready_o is high next cycle.
  - valid_i held high with a new value is ignored until then.
- Random: 1000 random radicands with random ready_i and en_pipe_i gaps -> every result matches the floor-sqrt model. No result is lost or duplicated.
